// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp controller and its prescaler.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } pwm_state_e;

  localparam int STEP_DEF   = 1;
  localparam int RATE_W_DEF = 4;
  localparam int CTRL_W     = 8;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Control-side bundle of the ramp controller, plus a debug view of the FSM state.
interface pwm_ramp_if
  import pwm_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
);
  // No ready/valid pair: load is a single-cycle strobe that is always accepted
  // (it captures target on that edge), and done is a single-cycle pulse.
  logic                ena;
  logic [CTRL_W-1:0]   target;
  logic                load;
  logic [RATE_W-1:0]   rate;
  logic                hold;
  logic [CTRL_W-1:0]   control;
  logic                busy;
  logic                done;
  pwm_state_e          state;

  modport master (
    output ena, target, load, rate, hold,
    input  control, busy, done, state
  );

  modport slave (
    input  ena, target, load, rate, hold,
    output control, busy, done, state
  );

endinterface

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: emits one tick every 2^rate enabled cycles.
module ramp_tick_gen
  import pwm_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  // Wide enough for the longest period, 2^(2^RATE_W - 1) cycles.
  localparam int CNT_W = (1 << RATE_W) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mask;

  assign mask = {CNT_W{1'b1}} >> (RATE_W'(CNT_W) - rate);
  assign tick = en & (cnt_q == mask);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps an 8-bit PWM control word toward a loaded target by STEP per prescaler tick.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int STEP   = STEP_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  pwm_ramp_if.slave bus
);

  pwm_state_e        state_q, state_d;
  logic [CTRL_W-1:0] tgt_q, tgt_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic              eval_q, eval_d;
  logic              done_q, done_d;

  logic              frozen;
  logic              tick;
  logic              ps_clr;
  logic              ps_en;
  logic [CTRL_W:0]   up_sum;
  logic [CTRL_W:0]   dn_diff;

  assign frozen = bus.hold | ~bus.ena;
  assign ps_en  = (state_q != IDLE) & ~frozen;
  assign ps_clr = bus.load | (eval_q & ~frozen);

  ramp_tick_gen #(.RATE_W(RATE_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ps_clr),
    .en    (ps_en),
    .rate  (bus.rate),
    .tick  (tick)
  );

  // Ninth bit catches carry on the way up and borrow on the way down.
  assign up_sum  = {1'b0, control_q} + 9'(STEP);
  assign dn_diff = {1'b0, control_q} - 9'(STEP);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    control_d = control_q;
    eval_d    = eval_q;
    done_d    = 1'b0;
    if (bus.load) begin
      // A load always wins: capture now, pick a direction on the next live edge.
      tgt_d  = bus.target;
      eval_d = 1'b1;
    end else if (!frozen) begin
      if (eval_q) begin
        eval_d = 1'b0;
        if (tgt_q > control_q) begin
          state_d = UP;
        end else if (tgt_q < control_q) begin
          state_d = DOWN;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else if (tick) begin
        case (state_q)
          UP: begin
            if (up_sum >= {1'b0, tgt_q}) begin
              control_d = tgt_q;
              state_d   = IDLE;
              done_d    = 1'b1;
            end else begin
              control_d = up_sum[CTRL_W-1:0];
            end
          end
          DOWN: begin
            if (dn_diff[CTRL_W] || (dn_diff[CTRL_W-1:0] <= tgt_q)) begin
              control_d = tgt_q;
              state_d   = IDLE;
              done_d    = 1'b1;
            end else begin
              control_d = dn_diff[CTRL_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      control_q <= '0;
      eval_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      control_q <= control_d;
      eval_q    <= eval_d;
      done_q    <= done_d;
    end
  end

  assign bus.control = control_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule
